// File: rtl/fru_pla_seq_unit.sv
// fru_pla_seq_unit: multi-channel registered PLA trigger with an ordered-hit sequencer
//   clk, rst          clock, asynchronous active-high reset
//   Inp               observable signals, sampled every cycle
//   CfgValid/Addr/Data  config write; Addr<NUM_CHANNELS -> channel shadow, ==NUM_CHANNELS -> control
//   CfgReady          write accepted (1 from the first edge after reset)
//   CfgErr            one-cycle pulse on a write to an unmapped address
//   ChanHit           registered per-channel PLA result
//   Stage             index of the channel the sequencer is waiting on
//   Trigger           one-cycle pulse when the sequence completes
//   FireCount         saturating count of Trigger pulses
module fru_pla_seq_unit #(
    parameter int INPUT_SIZE   = 8,
    parameter int SEGMENT_SIZE = 2,
    parameter int NUM_CHANNELS = 4,
    parameter int WINDOW_W     = 4,
    parameter int COUNT_W      = 8,
    localparam int SEL_W  = $clog2(INPUT_SIZE),
    localparam int MT_W   = 2**SEGMENT_SIZE,
    localparam int CFG_W  = SEGMENT_SIZE*SEL_W + MT_W,
    localparam int STG_W  = $clog2(NUM_CHANNELS),
    localparam int ADDR_W = STG_W + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUT_SIZE-1:0]   Inp,
    input  logic                    CfgValid,
    input  logic [ADDR_W-1:0]       CfgAddr,
    input  logic [CFG_W-1:0]        CfgData,
    output logic                    CfgReady,
    output logic                    CfgErr,
    output logic [NUM_CHANNELS-1:0] ChanHit,
    output logic [STG_W-1:0]        Stage,
    output logic                    Trigger,
    output logic [COUNT_W-1:0]      FireCount
);
    localparam logic [ADDR_W-1:0] CTL_ADDR = ADDR_W'(NUM_CHANNELS);

    logic [CFG_W-1:0]        shadow [NUM_CHANNELS];
    logic [CFG_W-1:0]        active [NUM_CHANNELS];
    logic                    enable;
    logic [WINDOW_W-1:0]     window, wcnt, wcnt_n;
    logic [STG_W-1:0]        len_m1, stage_n;
    logic [NUM_CHANNELS-1:0] hit;
    logic                    fire;

    logic wr, ctl_wr, ch_wr, commit;
    logic [STG_W-1:0] new_len_m1;
    assign wr         = CfgValid & CfgReady;
    assign ctl_wr     = wr && CfgAddr == CTL_ADDR;
    assign ch_wr      = wr && CfgAddr < CTL_ADDR;
    assign commit     = ctl_wr & CfgData[1];
    assign new_len_m1 = CfgData[2+WINDOW_W +: STG_W];

    // Selected inputs form the minterm index, so OR-ing the enabled minterms
    // reduces to picking one bit of the OR select.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [SEGMENT_SIZE-1:0] idx;
        logic [MT_W-1:0]         orsel;
        for (genvar k = 0; k < SEGMENT_SIZE; k++) begin : g_sel
            assign idx[k] = Inp[active[c][k*SEL_W +: SEL_W]];
        end
        assign orsel  = active[c][CFG_W-1 -: MT_W];
        assign hit[c] = orsel[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            enable   <= 1'b0;
            window   <= '0;
            len_m1   <= '0;
            CfgReady <= 1'b0;
            CfgErr   <= 1'b0;
        end else begin
            CfgReady <= 1'b1;
            CfgErr   <= wr && CfgAddr > CTL_ADDR;
            if (ch_wr)
                shadow[CfgAddr[STG_W-1:0]] <= CfgData;
            if (ctl_wr) begin
                enable <= CfgData[0];
                window <= CfgData[2 +: WINDOW_W];
                len_m1 <= new_len_m1;
            end
            if (commit)
                for (int i = 0; i < NUM_CHANNELS; i++)
                    active[i] <= shadow[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ChanHit   <= '0;
            Stage     <= '0;
            wcnt      <= '0;
            Trigger   <= 1'b0;
            FireCount <= '0;
        end else begin
            ChanHit   <= hit;
            Stage     <= stage_n;
            wcnt      <= wcnt_n;
            Trigger   <= fire;
            FireCount <= (fire && ~&FireCount) ? FireCount + 1'b1 : FireCount;
        end
    end

    always_comb begin
        stage_n = Stage;
        wcnt_n  = wcnt;
        fire    = 1'b0;
        if (!enable) begin
            stage_n = '0;
            wcnt_n  = '0;
        end else if (ChanHit[Stage] && Stage == len_m1) begin
            fire    = 1'b1;
            stage_n = '0;
            wcnt_n  = '0;
        end else if (ChanHit[Stage]) begin
            stage_n = Stage + 1'b1;
            wcnt_n  = window;
        end else if (Stage != '0 && window != '0) begin
            stage_n = (wcnt == WINDOW_W'(1)) ? '0 : Stage;
            wcnt_n  = (wcnt == WINDOW_W'(1)) ? '0 : wcnt - 1'b1;
        end
        // Commit restarts the sequence and drops any completion in flight;
        // a shrinking SeqLen must not leave the stage beyond the new end.
        if (commit) begin
            stage_n = '0;
            wcnt_n  = '0;
            fire    = 1'b0;
        end else if (ctl_wr && new_len_m1 < stage_n) begin
            stage_n = '0;
            wcnt_n  = '0;
        end
    end
endmodule

// File: tb/tb_fru_pla_seq_unit.sv
// tb_fru_pla_seq_unit: directed scoreboard bench for fru_pla_seq_unit
module tb_fru_pla_seq_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] Inp = '0;
    logic       CfgValid = 1'b0;
    logic [2:0] CfgAddr = '0;
    logic [9:0] CfgData = '0;
    logic       CfgReady, CfgErr, Trigger;
    logic [3:0] ChanHit;
    logic [1:0] Stage;
    logic [7:0] FireCount;

    typedef struct {
        int         cyc;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    fru_pla_seq_unit dut (
        .clk(clk), .rst(rst), .Inp(Inp),
        .CfgValid(CfgValid), .CfgAddr(CfgAddr), .CfgData(CfgData),
        .CfgReady(CfgReady), .CfgErr(CfgErr), .ChanHit(ChanHit),
        .Stage(Stage), .Trigger(Trigger), .FireCount(FireCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every Trigger pulse must match the oldest expected entry in cycle and count.
    always @(negedge clk) begin
        if (!rst && Trigger) begin
            if (sb.size() == 0) begin
                chk("trigger_unexpected", 32'(Trigger), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("trigger_cycle", cyc, e.cyc);
                chk("trigger_count", 32'(FireCount), 32'(e.cnt));
            end
        end
    end

    function automatic logic [9:0] chcfg(input logic [2:0] s0, input logic [2:0] s1, input logic [3:0] orsel);
        return {orsel, s1, s0};
    endfunction

    function automatic logic [9:0] ctl(input bit en, input bit cm, input logic [3:0] win, input int len);
        logic [1:0] l;
        l = 2'(len - 1);
        return {2'b00, l, win, cm, en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [9:0] d);
        CfgValid = 1'b1;
        CfgAddr  = a;
        CfgData  = d;
        tick();
        CfgValid = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] v);
        Inp = v;
        tick();
        Inp = '0;
    endtask

    task automatic expect_trig(input int at, input int cnt);
        sb.push_back('{at, 8'(cnt)});
    endtask

    initial begin
        int n;
        #3;
        chk("rst_cfgready", 32'(CfgReady), 0);
        chk("rst_stage", 32'(Stage), 0);
        chk("rst_firecount", 32'(FireCount), 0);
        chk("rst_chanhit", 32'(ChanHit), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("cfgready_up", 32'(CfgReady), 1);
        chk("idle_cfgerr", 32'(CfgErr), 0);
        chk("idle_trigger", 32'(Trigger), 0);
        Inp = 8'hFF;
        repeat (10) tick();
        chk("cleared_chanhit", 32'(ChanHit), 0);
        Inp = '0;

        // Single-stage AND of In0 and In1
        wr(3'd0, chcfg(3'd0, 3'd1, 4'b1000));
        wr(3'd4, ctl(1, 1, 4'd0, 1));
        n = cyc;
        expect_trig(n + 2, 1);
        Inp = 8'h03;
        tick();
        chk("and_chanhit", 32'(ChanHit), 32'h1);
        Inp = '0;
        tick();
        chk("and_firecount", 32'(FireCount), 1);

        // Three-stage sequence within a 3-cycle window
        wr(3'd0, chcfg(3'd0, 3'd0, 4'b1000));
        wr(3'd1, chcfg(3'd2, 3'd2, 4'b1000));
        wr(3'd2, chcfg(3'd4, 3'd4, 4'b1000));
        wr(3'd4, ctl(1, 1, 4'd3, 3));
        n = cyc;
        expect_trig(n + 5, 2);
        pulse(8'h01);
        tick();
        pulse(8'h04);
        pulse(8'h10);
        chk("seq_stage2", 32'(Stage), 2);
        tick();
        chk("seq_stage_back", 32'(Stage), 0);

        // Gap of 4 cycles exceeds the window and aborts
        pulse(8'h01);
        repeat (3) tick();
        chk("abort_pending_stage", 32'(Stage), 1);
        pulse(8'h04);
        chk("abort_stage", 32'(Stage), 0);
        pulse(8'h10);
        repeat (2) tick();
        chk("abort_stage_idle", 32'(Stage), 0);
        chk("abort_firecount", 32'(FireCount), 2);

        // Shadow write mid-sequence leaves active config alone until commit
        pulse(8'h01);
        tick();
        chk("shadow_stage1", 32'(Stage), 1);
        wr(3'd1, chcfg(3'd5, 3'd5, 4'b1000));
        pulse(8'h04);
        tick();
        chk("shadow_old_sel", 32'(Stage), 2);
        wr(3'd4, ctl(1, 1, 4'd3, 3));
        chk("commit_stage", 32'(Stage), 0);
        n = cyc;
        expect_trig(n + 5, 3);
        pulse(8'h01);
        tick();
        pulse(8'h20);
        pulse(8'h10);
        tick();

        // SeqLen=1 with ch0 held: back-to-back triggers until saturation
        wr(3'd4, ctl(1, 1, 4'd0, 1));
        n = cyc;
        for (int i = 0; i < 300; i++)
            expect_trig(n + 2 + i, (4 + i > 255) ? 255 : 4 + i);
        Inp = 8'h01;
        repeat (300) tick();
        Inp = '0;
        repeat (3) tick();
        chk("sat_firecount", 32'(FireCount), 32'hFF);
        chk("sat_trigger_low", 32'(Trigger), 0);

        // Unmapped address: error pulse, no control change
        wr(3'd5, 10'h000);
        chk("err_pulse", 32'(CfgErr), 1);
        tick();
        chk("err_clear", 32'(CfgErr), 0);
        n = cyc;
        expect_trig(n + 2, 8'hFF);
        pulse(8'h01);
        repeat (2) tick();

        // Asynchronous reset in the middle of a sequence
        wr(3'd4, ctl(1, 1, 4'd0, 3));
        pulse(8'h01);
        tick();
        pulse(8'h20);
        tick();
        chk("pre_rst_stage", 32'(Stage), 2);
        #2 rst = 1'b1;
        #1;
        chk("arst_stage", 32'(Stage), 0);
        chk("arst_trigger", 32'(Trigger), 0);
        chk("arst_firecount", 32'(FireCount), 0);
        chk("arst_cfgready", 32'(CfgReady), 0);
        tick();
        rst = 1'b0;
        Inp = 8'hFF;
        tick();
        chk("post_rst_ready", 32'(CfgReady), 1);
        wr(3'd4, ctl(1, 1, 4'd0, 1));
        repeat (3) tick();
        chk("post_rst_chanhit", 32'(ChanHit), 0);
        chk("post_rst_firecount", 32'(FireCount), 0);
        Inp = '0;
        tick();

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
